// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use interlock,
// data-memory freeze, EX redirect flush, fetch hold, stall counter and timeout flag.
module rv32i_hazard_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       FD_rs1,
  input  logic [4:0]       FD_rs2,
  input  logic [6:0]       FD_OP,
  input  logic [4:0]       DE_rd,
  input  logic [6:0]       DE_OP,
  input  logic             DE_RegWrite,
  input  logic             EX_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    REDIRECT = 2'b10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic rs1_used, rs2_used, lu, mem_stall;
  logic s_f, s_d, s_e, s_m, f_d, f_e;

  always_comb begin
    rs1_used = FD_OP inside {OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_JALR};
    rs2_used = FD_OP inside {OP_BRANCH, OP_STORE, OP_OP};
    lu = (DE_OP == OP_LOAD) && DE_RegWrite && (DE_rd != '0) &&
         (((DE_rd == FD_rs1) && rs1_used) || ((DE_rd == FD_rs2) && rs2_used));
    // Once frozen, only dmem_ready releases the pipeline; dmem_req no longer matters.
    mem_stall = (state_q == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
  end

  always_comb begin
    s_f     = 1'b0;
    s_d     = 1'b0;
    s_e     = 1'b0;
    s_m     = 1'b0;
    f_d     = 1'b0;
    f_e     = 1'b0;
    state_d = RUN;
    if (mem_stall) begin
      s_f     = 1'b1;
      s_d     = 1'b1;
      s_e     = 1'b1;
      s_m     = 1'b1;
      state_d = MEM_WAIT;
    end else if ((state_q == REDIRECT) && !imem_ready) begin
      s_f     = 1'b1;
      f_d     = 1'b1;
      state_d = REDIRECT;
    end else if (EX_redirect) begin
      f_d     = 1'b1;
      f_e     = 1'b1;
      state_d = REDIRECT;
    end else if (lu) begin
      s_f = 1'b1;
      s_d = 1'b1;
      f_e = 1'b1;
    end else if (!imem_ready) begin
      s_f = 1'b1;
      f_d = 1'b1;
    end
  end

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if ((state_q == MEM_WAIT) && !dmem_ready) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
      if (wait_d >= MAX_WAIT_C) timeout_d = 1'b1;
    end
    cnt_d = cnt_q;
    if (s_f && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_F     = rst_n & s_f;
  assign stall_D     = rst_n & s_d;
  assign stall_E     = rst_n & s_e;
  assign stall_M     = rst_n & s_m;
  assign flush_D     = rst_n & f_d;
  assign flush_E     = rst_n & f_e;
  assign state       = state_q;
  assign stall_count = cnt_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Scoreboard bench for rv32i_hazard_ctrl: directed scenarios then random traffic,
// expectations from a behavioural model of the sequencing rules.
module tb_rv32i_hazard_ctrl;

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned WAIT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       FD_rs1 = '0, FD_rs2 = '0, DE_rd = '0;
  logic [6:0]       FD_OP = '0, DE_OP = '0;
  logic             DE_RegWrite = 1'b0, EX_redirect = 1'b0;
  logic             dmem_req = 1'b0, dmem_ready = 1'b0, imem_ready = 1'b1;
  logic             stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout;

  rv32i_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .FD_rs1(FD_rs1), .FD_rs2(FD_rs2), .FD_OP(FD_OP),
    .DE_rd(DE_rd), .DE_OP(DE_OP), .DE_RegWrite(DE_RegWrite),
    .EX_redirect(EX_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .imem_ready(imem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E),
    .state(state), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       ctl;   // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             tmo;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 running, 1 waiting on data memory, 2 refetching after redirect.
  int m_mode    = 0;
  int m_waited  = 0;
  int m_stalls  = 0;
  bit m_timeout = 1'b0;

  function automatic bit reads_rs1(input logic [6:0] op);
    return op == BRANCH || op == LOAD || op == STORE || op == OPIMM || op == OPR || op == JALR;
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == BRANCH || op == STORE || op == OPR;
  endfunction

  task automatic model_cycle(output exp_t e);
    bit sf, sd, se, sm, fd, fe, hazard, frozen;
    int nxt;
    if (!rst_n) begin
      m_mode = 0; m_waited = 0; m_stalls = 0; m_timeout = 1'b0;
      e.ctl = '0; e.st = 2'b00; e.cnt = '0; e.tmo = 1'b0;
      return;
    end
    e.st  = 2'(m_mode);
    e.cnt = CNT_W'(m_stalls);
    e.tmo = m_timeout;
    {sf, sd, se, sm, fd, fe} = '0;
    nxt = 0;
    hazard = DE_OP == LOAD && DE_RegWrite && DE_rd != 0 &&
             ((DE_rd == FD_rs1 && reads_rs1(FD_OP)) || (DE_rd == FD_rs2 && reads_rs2(FD_OP)));
    frozen = (m_mode == 1) ? !dmem_ready : (dmem_req && !dmem_ready);
    if (frozen) begin
      {sf, sd, se, sm} = 4'b1111; nxt = 1;
    end else if (m_mode == 2 && !imem_ready) begin
      sf = 1; fd = 1; nxt = 2;
    end else if (EX_redirect) begin
      fd = 1; fe = 1; nxt = 2;
    end else if (hazard) begin
      sf = 1; sd = 1; fe = 1;
    end else if (!imem_ready) begin
      sf = 1; fd = 1;
    end
    e.ctl = {sf, sd, se, sm, fd, fe};
    if (sf && m_stalls < CNT_MAX) m_stalls++;
    if (m_mode == 1 && !dmem_ready) begin
      m_waited++;
      if (m_waited >= int'(MAX_WAIT)) m_timeout = 1'b1;
    end else begin
      m_waited = 0;
    end
    m_mode = nxt;
  endtask

  task automatic drive(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] fop, input logic [4:0] rd, input logic [6:0] dop,
                       input bit rw, input bit redir, input bit dreq, input bit drdy,
                       input bit irdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; FD_rs1 = rs1; FD_rs2 = rs2; FD_OP = fop; DE_rd = rd; DE_OP = dop;
    DE_RegWrite = rw; EX_redirect = redir; dmem_req = dreq; dmem_ready = drdy;
    imem_ready = irdy;
    model_cycle(e);
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares the presented outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctl", int'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}), int'(e.ctl));
        check("state", int'(state), int'(e.st));
        check("stall_count", int'(stall_count), int'(e.cnt));
        check("mem_timeout", int'(mem_timeout), int'(e.tmo));
      end
    end
  end

  logic [6:0] ops [9] = '{OPR, OPIMM, LOAD, STORE, BRANCH, JALR, LUI, JAL, AUIPC};

  initial begin
    // reset
    drive(0, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 1);
    drive(0, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 1);
    // load-use on rs1, then the bubble, then rd=x0
    drive(1, 5, 0, OPR, 5, LOAD, 1, 0, 0, 0, 1);
    drive(1, 5, 0, OPR, 0, OPIMM, 0, 0, 0, 0, 1);
    drive(1, 0, 0, OPR, 0, LOAD, 1, 0, 0, 0, 1);
    // LUI does not read rs1; store data via rs2 does interlock
    drive(1, 5, 0, LUI, 5, LOAD, 1, 0, 0, 0, 1);
    drive(1, 1, 5, STORE, 5, LOAD, 1, 0, 0, 0, 1);
    drive(1, 1, 5, OPIMM, 5, LOAD, 1, 0, 0, 0, 1);
    // 3-cycle data-memory wait
    repeat (3) drive(1, 0, 0, OPR, 0, OPR, 0, 0, 1, 0, 1);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 1, 1, 1);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 1);
    // redirect held in EX during a 2-cycle wait, then refetch with imem miss
    repeat (2) drive(1, 0, 0, OPR, 0, JAL, 1, 1, 1, 0, 1);
    drive(1, 0, 0, OPR, 0, JAL, 1, 1, 1, 1, 1);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 0);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 1, 0, 0);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 0, 1, 1);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 1);
    // timeout after MAX_WAIT waiting cycles, sticky afterwards
    repeat (6) drive(1, 0, 0, OPR, 0, OPR, 0, 0, 1, 0, 1);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 1, 1, 1);
    repeat (2) drive(1, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 1);
    // asynchronous reset in the middle of a data-memory wait
    repeat (6) drive(1, 0, 0, OPR, 0, OPR, 0, 0, 1, 0, 1);
    drive(0, 0, 0, OPR, 0, OPR, 0, 0, 1, 0, 1);
    drive(1, 0, 0, OPR, 0, OPR, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] dop;
      dop = ($urandom_range(1) == 1) ? LOAD : ops[$urandom_range(8)];
      drive($urandom_range(99) != 0,
            5'($urandom_range(3)), 5'($urandom_range(3)), ops[$urandom_range(8)],
            5'($urandom_range(3)), dop, $urandom_range(3) != 0,
            $urandom_range(9) == 0, $urandom_range(9) < 3, $urandom_range(9) < 6,
            $urandom_range(3) != 0);
    end
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
